// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: state encoding,
// instruction step sizes and the address alignment check used by the branch unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam logic [2:0] STEP_16 = 3'd2;
    localparam logic [2:0] STEP_32 = 3'd4;

    // With compressed instructions only halfword alignment is needed.
    function automatic logic is_aligned(input logic [1:0] low_bits, input logic c_ext);
        if (c_ext) begin
            return !low_bits[0];
        end
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch/execute-facing bundle of the program counter generator: request
// inputs from the pipeline and the fetch address outputs.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            Fetch_Ready;
    logic            Stall;
    logic            Instr_Compressed;
    logic            Redirect_Valid;
    logic [XLEN-1:0] Redirect_Target;
    logic            Trap_Req;
    logic            Mret_Req;
    logic            Halt_Req;
    logic            Resume;

    logic [XLEN-1:0] Program_Count;
    logic [XLEN-1:0] Program_Count_Off;
    logic            Fetch_Valid;
    logic [XLEN-1:0] Epc;
    logic            Misaligned_Fault;

    // master is the pipeline side that raises requests; slave is pc_gen itself
    modport master (
        output Fetch_Ready, Stall, Instr_Compressed, Redirect_Valid, Redirect_Target,
               Trap_Req, Mret_Req, Halt_Req, Resume,
        input  Program_Count, Program_Count_Off, Fetch_Valid, Epc, Misaligned_Fault
    );

    modport slave (
        input  Fetch_Ready, Stall, Instr_Compressed, Redirect_Valid, Redirect_Target,
               Trap_Req, Mret_Req, Halt_Req, Resume,
        output Program_Count, Program_Count_Off, Fetch_Valid, Epc, Misaligned_Fault
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational priority selector for the program counter: resolves trap,
// return, redirect, halt and sequential advance into next PC/Epc/state/fault.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int              C_EXT       = 0
) (
    input  pc_state_t       state,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] pc_off,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic            mret_req,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] next_epc,
    output pc_state_t       next_state,
    output logic            next_fault
);

    logic target_ok;

    assign target_ok = is_aligned(redirect_target[1:0], C_EXT != 0);

    // Strict priority: a lower request in the same cycle is simply dropped.
    always_comb begin
        next_pc    = pc;
        next_epc   = epc;
        next_state = state;
        next_fault = 1'b0;
        case (state)
            BOOT: begin
                next_state = RUN;
            end
            RUN: begin
                if (trap_req) begin
                    next_epc = pc;
                    next_pc  = TRAP_VECTOR;
                end else if (mret_req) begin
                    next_pc = epc;
                end else if (redirect_valid) begin
                    if (target_ok) begin
                        next_pc = redirect_target;
                    end else begin
                        next_epc   = pc;
                        next_pc    = TRAP_VECTOR;
                        next_fault = 1'b1;
                    end
                end else if (halt_req) begin
                    next_state = HALT;
                end else if (fetch_ready && !stall) begin
                    next_pc = pc_off;
                end
            end
            HALT: begin
                if (trap_req) begin
                    next_epc   = pc;
                    next_pc    = TRAP_VECTOR;
                    next_state = RUN;
                end else if (resume) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter generator: holds PC, saved exception PC, state
// and the misaligned-redirect pulse; next values come from pc_next_sel.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              C_EXT        = 0
) (
    input  logic     Clk_Core,
    input  logic     Rst_Core_N,
    pc_gen_if.slave  pc_bus
);

    localparam bit VECTORS_OK = is_aligned(RESET_VECTOR[1:0], C_EXT != 0) &&
                                is_aligned(TRAP_VECTOR[1:0], C_EXT != 0);

    if (!VECTORS_OK) begin : g_vector_check
        $error("pc_gen: RESET_VECTOR or TRAP_VECTOR violates the alignment rule");
    end

    pc_state_t       state_q;
    pc_state_t       state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] epc_d;
    logic            fault_q;
    logic            fault_d;
    logic [2:0]      step;
    logic [XLEN-1:0] pc_off;

    assign step   = ((C_EXT != 0) && pc_bus.Instr_Compressed) ? STEP_16 : STEP_32;
    assign pc_off = pc_q + XLEN'(step);

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .C_EXT       (C_EXT)
    ) u_next_sel (
        .state           (state_q),
        .pc              (pc_q),
        .epc             (epc_q),
        .pc_off          (pc_off),
        .fetch_ready     (pc_bus.Fetch_Ready),
        .stall           (pc_bus.Stall),
        .redirect_valid  (pc_bus.Redirect_Valid),
        .redirect_target (pc_bus.Redirect_Target),
        .trap_req        (pc_bus.Trap_Req),
        .mret_req        (pc_bus.Mret_Req),
        .halt_req        (pc_bus.Halt_Req),
        .resume          (pc_bus.Resume),
        .next_pc         (pc_d),
        .next_epc        (epc_d),
        .next_state      (state_d),
        .next_fault      (fault_d)
    );

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            fault_q <= fault_d;
        end
    end

    assign pc_bus.Program_Count     = pc_q;
    assign pc_bus.Program_Count_Off = pc_off;
    assign pc_bus.Fetch_Valid       = (state_q == RUN);
    assign pc_bus.Epc               = epc_q;
    assign pc_bus.Misaligned_Fault  = fault_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: drives a 4-byte-only and a compressed-capable instance with
// the same directed and random requests and compares both against a reference model.
module tb_pc_gen;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam logic [31:0] TRAP_ADDR = 32'h0000_0100;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        int          mode;
        logic        fault;
    } model_t;

    logic        clk;
    logic        rst_n;
    logic        ready, stall, comp, redir, trap, mret, halt, resume;
    logic [31:0] target;

    int checks = 0;
    int errors = 0;
    model_t mdl [2];

    pc_gen_if #(.XLEN(32)) if32 ();
    pc_gen_if #(.XLEN(32)) if16 ();

    assign if32.Fetch_Ready      = ready;
    assign if32.Stall            = stall;
    assign if32.Instr_Compressed = comp;
    assign if32.Redirect_Valid   = redir;
    assign if32.Redirect_Target  = target;
    assign if32.Trap_Req         = trap;
    assign if32.Mret_Req         = mret;
    assign if32.Halt_Req         = halt;
    assign if32.Resume           = resume;

    assign if16.Fetch_Ready      = ready;
    assign if16.Stall            = stall;
    assign if16.Instr_Compressed = comp;
    assign if16.Redirect_Valid   = redir;
    assign if16.Redirect_Target  = target;
    assign if16.Trap_Req         = trap;
    assign if16.Mret_Req         = mret;
    assign if16.Halt_Req         = halt;
    assign if16.Resume           = resume;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP_ADDR), .C_EXT(0)) dut32 (
        .Clk_Core   (clk),
        .Rst_Core_N (rst_n),
        .pc_bus     (if32)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP_ADDR), .C_EXT(1)) dut16 (
        .Clk_Core   (clk),
        .Rst_Core_N (rst_n),
        .pc_bus     (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1 is the compressed-capable one.
    function automatic logic [31:0] stepOf(int k);
        return (k == 1 && comp) ? 32'd2 : 32'd4;
    endfunction

    function automatic bit alignedFor(int k, logic [31:0] a);
        return (a % ((k == 1) ? 32'd2 : 32'd4)) == 0;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mdl[k].pc    = 32'h0;
            mdl[k].epc   = 32'h0;
            mdl[k].mode  = M_BOOT;
            mdl[k].fault = 1'b0;
        end
    endtask

    task automatic takeTrap(int k);
        mdl[k].epc = mdl[k].pc;
        mdl[k].pc  = TRAP_ADDR;
    endtask

    task automatic modelAdvance(int k);
        logic [31:0] seqPc;
        seqPc = mdl[k].pc + stepOf(k);
        mdl[k].fault = 1'b0;
        if (mdl[k].mode == M_BOOT) begin
            mdl[k].mode = M_RUN;
        end else if (mdl[k].mode == M_HALT) begin
            if (trap) begin
                takeTrap(k);
                mdl[k].mode = M_RUN;
            end else if (resume) begin
                mdl[k].mode = M_RUN;
            end
        end else if (trap) begin
            takeTrap(k);
        end else if (mret) begin
            mdl[k].pc = mdl[k].epc;
        end else if (redir && alignedFor(k, target)) begin
            mdl[k].pc = target;
        end else if (redir) begin
            takeTrap(k);
            mdl[k].fault = 1'b1;
        end else if (halt) begin
            mdl[k].mode = M_HALT;
        end else if (ready && !stall) begin
            mdl[k].pc = seqPc;
        end
    endtask

    task automatic checkEq(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(int k, string tag);
        logic [31:0] obsPc, obsOff, obsEpc;
        logic        obsValid, obsFault;
        obsPc    = (k == 0) ? if32.Program_Count     : if16.Program_Count;
        obsOff   = (k == 0) ? if32.Program_Count_Off : if16.Program_Count_Off;
        obsEpc   = (k == 0) ? if32.Epc               : if16.Epc;
        obsValid = (k == 0) ? if32.Fetch_Valid       : if16.Fetch_Valid;
        obsFault = (k == 0) ? if32.Misaligned_Fault  : if16.Misaligned_Fault;
        checkEq($sformatf("%s/c%0d/pc", tag, k), obsPc, mdl[k].pc);
        checkEq($sformatf("%s/c%0d/off", tag, k), obsOff, mdl[k].pc + stepOf(k));
        checkEq($sformatf("%s/c%0d/epc", tag, k), obsEpc, mdl[k].epc);
        checkEq($sformatf("%s/c%0d/valid", tag, k), {31'b0, obsValid}, {31'b0, mdl[k].mode == M_RUN});
        checkEq($sformatf("%s/c%0d/fault", tag, k), {31'b0, obsFault}, {31'b0, mdl[k].fault});
    endtask

    // Called at a falling edge; drives inputs, clocks once, checks both instances.
    task automatic applyStimulus(bit r, bit s, bit c, bit rv, logic [31:0] t,
                                 bit tr, bit mr, bit h, bit res, string tag);
        ready = r; stall = s; comp = c; redir = rv; target = t;
        trap = tr; mret = mr; halt = h; resume = res;
        @(posedge clk);
        #1;
        modelAdvance(0);
        modelAdvance(1);
        checkOutput(0, tag);
        checkOutput(1, tag);
        @(negedge clk);
    endtask

    task automatic idle(int n, string tag);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0, 0, tag);
    endtask

    task automatic pulseReset(string tag);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput(0, tag);
        checkOutput(1, tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rt;
        rst_n = 1'b0;
        ready = 1'b1; stall = 0; comp = 0; redir = 0; target = 0;
        trap = 0; mret = 0; halt = 0; resume = 0;
        modelReset();
        #2;
        checkOutput(0, "reset");
        checkOutput(1, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // boot, then sequential fetch 0,4,8
        idle(3, "seq");
        checkEq("seq_pc8", if32.Program_Count, 32'h8);

        // stall holds; redirect wins over stall in 2nd stall cycle
        applyStimulus(1, 1, 0, 0, 32'h0,  0, 0, 0, 0, "stall1");
        applyStimulus(1, 1, 0, 1, 32'h40, 0, 0, 0, 0, "stall_redir");
        applyStimulus(1, 1, 0, 0, 32'h0,  0, 0, 0, 0, "stall3");
        checkEq("stall_redir_pc", if32.Program_Count, 32'h40);

        // trap beats redirect, then return
        applyStimulus(1, 0, 0, 1, 32'h80, 1, 0, 0, 0, "trap_vs_redir");
        checkEq("trap_epc", if32.Epc, 32'h40);
        applyStimulus(1, 0, 0, 0, 32'h0,  0, 1, 0, 0, "mret");

        // compressed stepping and misaligned targets
        applyStimulus(1, 0, 0, 1, 32'h10, 0, 0, 0, 0, "to10");
        applyStimulus(1, 0, 1, 0, 32'h0,  0, 0, 0, 0, "comp_step");
        checkEq("comp_pc16", if16.Program_Count, 32'h12);
        applyStimulus(1, 0, 0, 1, 32'h13, 0, 0, 0, 0, "mis13");
        checkEq("mis13_fault16", {31'b0, if16.Misaligned_Fault}, 32'h1);
        applyStimulus(1, 0, 0, 1, 32'h12, 0, 0, 0, 0, "mis12");
        applyStimulus(1, 0, 0, 1, 32'h13, 0, 0, 0, 0, "b2b_a");
        applyStimulus(1, 0, 0, 1, 32'h13, 0, 0, 0, 0, "b2b_b");
        idle(1, "fault_clear");

        // halt, ignored redirect/mret, resume
        applyStimulus(1, 0, 0, 1, 32'h20, 0, 0, 0, 0, "to20");
        applyStimulus(1, 0, 0, 0, 32'h0,  0, 0, 1, 0, "halt");
        idle(2, "halted");
        applyStimulus(1, 0, 0, 1, 32'h60, 0, 1, 0, 0, "halt_redir");
        idle(2, "halted2");
        checkEq("halt_pc", if32.Program_Count, 32'h20);
        applyStimulus(1, 0, 0, 0, 32'h0,  0, 0, 0, 1, "resume");
        idle(1, "after_resume");
        checkEq("resume_pc", if32.Program_Count, 32'h24);

        pulseReset("midreset");
        idle(2, "post_reset");

        // wrap around the top of the address space
        applyStimulus(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, "to_top");
        idle(1, "wrap");
        checkEq("wrap_pc", if32.Program_Count, 32'h0);

        // trap taken from halt
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 1, 0, "halt2");
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 0, 0, 0, "halt_trap");

        // random phase
        for (int i = 0; i < 600; i++) begin
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            if ($urandom_range(0, 199) == 0) begin
                pulseReset("rand_reset");
            end else begin
                applyStimulus($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 30,
                              $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 15, rt,
                              $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
                              $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 30, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the core's fetch stage, succeeding the single-cycle PC. Produces the fetch address and its sequential successor with configurable width, reset and trap vectors, and optional 16-bit instruction stepping. Adds fetch handshaking, stall, a redirect/trap/return priority scheme, a saved exception PC, misaligned-target trapping and a halt state. Sits between the fetch memory interface and the branch/CSR logic of the execute stage.

## Interface
- XLEN, 32, width of all address ports.
- RESET_VECTOR, 32'h0000_0000, Program_Count value after reset; must satisfy the alignment rule.
- TRAP_VECTOR, 32'h0000_0100, target on trap or misaligned redirect; must satisfy the alignment rule.
- C_EXT, 0, 1 enables 2-byte stepping and 2-byte alignment.

Ports:
- Clk_Core  in  1  core clock, all state on rising edge.
- Rst_Core_N  in  1  reset, asynchronous, active-low.
- Fetch_Ready  in  1  memory accepts the current fetch address.
- Stall  in  1  pipeline hold; blocks sequential advance only.
- Instr_Compressed  in  1  current instruction is 16-bit; ignored when C_EXT=0.
- Redirect_Valid  in  1  branch or jump taken this cycle.
- Redirect_Target  in  XLEN  branch or jump target.
- Trap_Req  in  1  exception or interrupt taken.
- Mret_Req  in  1  return from trap.
- Halt_Req  in  1  enter halt (wfi/ebreak).
- Resume  in  1  leave halt.
- Program_Count  out  XLEN  current fetch address, registered.
- Program_Count_Off  out  XLEN  Program_Count + step, combinational.
- Fetch_Valid  out  1  Program_Count is a valid fetch request.
- Epc  out  XLEN  saved exception PC, registered.
- Misaligned_Fault  out  1  one-cycle registered pulse on a misaligned redirect.

## Operation
- States: BOOT, RUN, HALT. Fetch_Valid = (state == RUN).
- Reset: state BOOT, Program_Count = RESET_VECTOR, Epc = 0, Misaligned_Fault = 0.
- BOOT: all requests ignored; unconditionally moves to RUN on the next edge with PC unchanged.
- step = 2 if C_EXT && Instr_Compressed, else 4. Program_Count_Off = Program_Count + step, modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 0.
- Alignment rule: C_EXT=1 requires bit 0 clear; C_EXT=0 requires bits [1:0] clear.
- RUN next-PC priority, highest first:
  - Trap_Req: Epc <= Program_Count, PC <= TRAP_VECTOR.
  - Mret_Req: PC <= Epc.
  - Redirect_Valid with aligned target: PC <= Redirect_Target.
  - Redirect_Valid with misaligned target: Epc <= Program_Count, PC <= TRAP_VECTOR, Misaligned_Fault <= 1 for one cycle.
  - Halt_Req: PC held, state <= HALT.
  - Fetch_Ready && !Stall: PC <= Program_Count_Off.
  - Otherwise: PC held.
- Trap, mret and redirect events take effect regardless of Stall and Fetch_Ready.
- HALT: PC held and Fetch_Valid = 0.
  - Trap_Req: takes the trap path and returns to RUN.
  - Resume: returns to RUN with PC unchanged.
  - Redirect_Valid, Mret_Req and Halt_Req are ignored.
- Simultaneous requests resolve strictly by the priority list; a lower request in the same cycle is dropped, not queued.

## Timing
- Every registered output updates one edge after the causing input is sampled. Program_Count_Off follows Program_Count and Instr_Compressed in the same cycle.
- After reset deassertion, the first edge enters RUN; Fetch_Valid rises one edge later than reset release.
- Reset mid-operation: outputs return to reset values immediately, without waiting for a clock edge.
- Misaligned_Fault is high for exactly one cycle per event. Back-to-back misaligned redirects produce back-to-back pulses.

## Structure
- Package pc_pkg holds:
  - state enum (BOOT, RUN, HALT);
  - step constants (STEP_16 = 2, STEP_32 = 4);
  - alignment-check function shared with the branch unit.
- Sub-module pc_next_sel: the combinational priority mux producing next PC, next Epc, next state and fault. pc_gen holds the registers.
- Simulation-only check that RESET_VECTOR and TRAP_VECTOR satisfy the alignment rule.

## Test plan
- Reset release, Fetch_Ready=1, Stall=0, RESET_VECTOR=0 -> Fetch_Valid rises after BOOT; PC sequence 0, 4, 8, 12 with Program_Count_Off = PC+4 each cycle.
- Stall=1 for 3 cycles at PC=8, with Redirect_Valid to 0x40 in the 2nd stall cycle -> PC stays 8, then becomes 0x40 despite the stall.
- Trap_Req and Redirect_Valid in the same cycle at PC=0x40 -> PC=0x100, Epc=0x40. Then Mret_Req -> PC=0x40.
- C_EXT=1, Instr_Compressed=1 at PC=0x10 -> Off=0x12, next PC=0x12. Redirect to 0x13 -> PC=0x100, Epc=0x12, Misaligned_Fault pulses one cycle. C_EXT=0: redirect to 0x12 faults.
- Halt_Req at PC=0x20 -> Fetch_Valid=0 and PC held for 5 cycles; a redirect during halt is ignored; Resume -> PC continues 0x20, 0x24.
- PC=0xFFFF_FFFC advancing -> PC wraps to 0. Rst_Core_N low mid-run -> all outputs return to reset values before the next clock edge.
